// File: rtl/motor_ctrl_n_pkg.sv
// Shared definitions for the N-channel motor controller: command field layout,
// opcodes, channel modes and the decoded-command record.
package motor_ctrl_n_pkg;

  localparam logic [2:0] OP_SET_RAMP = 3'd0;
  localparam logic [2:0] OP_SET_IMM  = 3'd1;
  localparam logic [2:0] OP_BRAKE    = 3'd2;
  localparam logic [2:0] OP_COAST    = 3'd3;
  localparam logic [2:0] OP_READ     = 3'd4;

  localparam int OP_MSB   = 23;
  localparam int OP_LSB   = 21;
  localparam int CH_MSB   = 20;
  localparam int CH_LSB   = 17;
  localparam int DIR_BIT  = 16;
  localparam int DUTY_MSB = 15;
  localparam int DUTY_LSB = 0;

  localparam logic [3:0] OVF_TAG = 4'hF;

  localparam logic [1:0] MODE_COAST = 2'd0;
  localparam logic [1:0] MODE_DRIVE = 2'd1;
  localparam logic [1:0] MODE_BRAKE = 2'd2;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  ch;
    logic        dir;
    logic [15:0] duty;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [23:0] word);
    cmd_t c;
    c.op   = word[OP_MSB:OP_LSB];
    c.ch   = word[CH_MSB:CH_LSB];
    c.dir  = word[DIR_BIT];
    c.duty = word[DUTY_MSB:DUTY_LSB];
    return c;
  endfunction

endpackage

// File: rtl/motor_ctrl_n_channel.sv
// One motor channel: drive mode, ramped duty with safe direction reversal,
// bridge/PWM outputs and a debounced, saturating encoder counter.
module motor_channel
  import motor_ctrl_n_pkg::*;
#(
  parameter int PWM_BITS  = 11,
  parameter int CNT_BITS  = 12,
  parameter int DEB_DELAY = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_op,
  input  logic                cmd_dir,
  input  logic [PWM_BITS-1:0] cmd_duty,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                clr,
  input  logic                ppr,
  output logic                ina,
  output logic                inb,
  output logic                pwm,
  output logic [CNT_BITS-1:0] cnt,
  output logic                pending
);

  localparam int DW = $clog2(DEB_DELAY + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_DELAY - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [1:0]          mode_reg, mode_next;
  logic                dir_reg, dir_next;
  logic                dir_req_reg, dir_req_next;
  logic [PWM_BITS-1:0] cur_reg, cur_next;
  logic [PWM_BITS-1:0] tgt_reg, tgt_next;

  logic                raw_reg;
  logic                stable_reg;
  logic [DW-1:0]       deb_cnt_reg;
  logic                pulse;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                pend_reg, pend_next;

  always_comb begin
    mode_next    = mode_reg;
    dir_next     = dir_reg;
    dir_req_next = dir_req_reg;
    cur_next     = cur_reg;
    tgt_next     = tgt_reg;
    // A pending reversal first winds the duty down; the applied direction
    // only changes once the bridge has actually reached zero.
    if (mode_reg == MODE_DRIVE) begin
      if (dir_req_reg != dir_reg) begin
        if (cur_reg == '0)
          dir_next = dir_req_reg;
        else if (tick)
          cur_next = cur_reg - 1'b1;
      end else if (tick) begin
        if (cur_reg < tgt_reg)
          cur_next = cur_reg + 1'b1;
        else if (cur_reg > tgt_reg)
          cur_next = cur_reg - 1'b1;
      end
    end
    if (cmd_valid) begin
      case (cmd_op)
        OP_SET_RAMP: begin
          mode_next    = MODE_DRIVE;
          tgt_next     = cmd_duty;
          dir_req_next = cmd_dir;
        end
        OP_SET_IMM: begin
          mode_next    = MODE_DRIVE;
          cur_next     = cmd_duty;
          tgt_next     = cmd_duty;
          dir_next     = cmd_dir;
          dir_req_next = cmd_dir;
        end
        OP_BRAKE, OP_COAST: begin
          mode_next    = (cmd_op == OP_BRAKE) ? MODE_BRAKE : MODE_COAST;
          cur_next     = '0;
          tgt_next     = '0;
          dir_next     = dir_reg;
          dir_req_next = dir_reg;
        end
        default: ;
      endcase
    end
  end

  assign pulse = raw_reg && !stable_reg && (deb_cnt_reg == DEB_LAST);

  always_comb begin
    cnt_next  = cnt_reg;
    pend_next = pend_reg;
    if (clr) begin
      cnt_next  = CNT_BITS'(pulse);
      pend_next = 1'b0;
    end else if (!pend_reg && pulse) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == CNT_MAX - 1'b1)
        pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg    <= MODE_COAST;
      dir_reg     <= 1'b0;
      dir_req_reg <= 1'b0;
      cur_reg     <= '0;
      tgt_reg     <= '0;
      raw_reg     <= 1'b0;
      stable_reg  <= 1'b0;
      deb_cnt_reg <= '0;
      cnt_reg     <= '0;
      pend_reg    <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      dir_reg     <= dir_next;
      dir_req_reg <= dir_req_next;
      cur_reg     <= cur_next;
      tgt_reg     <= tgt_next;
      raw_reg     <= ppr;
      if (raw_reg == stable_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        stable_reg  <= raw_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
    end
  end

  logic drive_on, brake_on, nonzero;
  assign drive_on = (mode_reg == MODE_DRIVE);
  assign brake_on = (mode_reg == MODE_BRAKE);
  assign nonzero  = (cur_reg != '0);

  assign ina     = brake_on | (drive_on & dir_reg & nonzero);
  assign inb     = brake_on | (drive_on & ~dir_reg & nonzero);
  assign pwm     = brake_on | (drive_on & (pwm_cnt < cur_reg));
  assign cnt     = cnt_reg;
  assign pending = pend_reg;

endmodule

// File: rtl/motor_ctrl_n.sv
// N-channel DC motor controller: command decode, shared PWM counter and ramp
// prescaler, per-channel instances and the single-slot report arbiter.
module motor_ctrl_n
  import motor_ctrl_n_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int PWM_BITS  = 11,
  parameter int CNT_BITS  = 12,
  parameter int DEB_DELAY = 5,
  parameter int RAMP_DIV  = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [CHANNELS-1:0] motor_ina,
  output logic [CHANNELS-1:0] motor_inb,
  output logic [CHANNELS-1:0] motor_pwm,
  input  logic [CHANNELS-1:0] ppr_sence,
  input  logic [3:0]          in_ctrl,
  input  logic [23:0]         in_data,
  input  logic                in_wr,
  output logic [3:0]          out_ctrl,
  output logic [23:0]         out_data,
  output logic                out_wr
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  cmd_t                cmd;
  logic                is_read;
  logic                unused_duty;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PW-1:0]       presc_reg;
  logic                tick;

  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] pending;
  logic [CNT_BITS-1:0] cnt [CHANNELS];

  logic [CNT_BITS-1:0] rd_cnt, ovf_cnt;
  logic [3:0]          grant_idx;
  logic                found;

  logic                out_wr_reg;
  logic [3:0]          out_ctrl_reg;
  logic [23:0]         out_data_reg;

  assign cmd         = decode_cmd(in_data);
  assign is_read     = in_wr && (cmd.op == OP_READ);
  assign unused_duty = ^cmd.duty;
  assign tick        = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
      presc_reg   <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      presc_reg   <= tick ? '0 : presc_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    // Out-of-range channel numbers never match, so they select nothing.
    assign sel[gi] = (cmd.ch == 4'(gi));
    assign clr[gi] = (is_read && sel[gi]) || grant[gi];

    motor_channel #(
      .PWM_BITS (PWM_BITS),
      .CNT_BITS (CNT_BITS),
      .DEB_DELAY(DEB_DELAY)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(in_wr && !cmd.op[2] && sel[gi]),
      .cmd_op   (cmd.op),
      .cmd_dir  (cmd.dir),
      .cmd_duty (PWM_BITS'(cmd.duty)),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt_reg),
      .clr      (clr[gi]),
      .ppr      (ppr_sence[gi]),
      .ina      (motor_ina[gi]),
      .inb      (motor_inb[gi]),
      .pwm      (motor_pwm[gi]),
      .cnt      (cnt[gi]),
      .pending  (pending[gi])
    );
  end

  // READ owns the report slot; otherwise the lowest pending channel wins.
  always_comb begin
    rd_cnt    = '0;
    ovf_cnt   = '0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel[i])
        rd_cnt = cnt[i];
      if (!is_read && pending[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = 4'(i);
        ovf_cnt   = cnt[i];
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr_reg   <= 1'b0;
      out_ctrl_reg <= '0;
      out_data_reg <= '0;
    end else begin
      out_wr_reg <= is_read || found;
      if (is_read) begin
        out_ctrl_reg <= in_ctrl;
        out_data_reg <= {cmd.ch, 20'(rd_cnt)};
      end else if (found) begin
        out_ctrl_reg <= OVF_TAG;
        out_data_reg <= {grant_idx, 20'(ovf_cnt)};
      end
    end
  end

  assign out_wr   = out_wr_reg;
  assign out_ctrl = out_ctrl_reg;
  assign out_data = out_data_reg;

endmodule
